// File: rtl/mux_rr_nto1_reg_if.sv
// Handshake bundle for the N-to-1 registered mux: N producer channels in,
// one registered consumer channel out. The mux itself is the slave side.
interface mux_rr_nto1_reg_if #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SELW  = $clog2(N)
);
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic [SELW-1:0]    out_ch;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_ch
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_ch
   );
endinterface

// File: rtl/mux_rr_nto1_reg.sv
// N-to-1 registered mux with valid/ready on every channel. Selection is a
// fixed external index (mode = 0) or round-robin starting after the last
// granted channel (mode = 1). One output register stage; the register can
// reload in the same cycle its word is consumed, giving full throughput.
module mux_rr_nto1_reg #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SELW  = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mode,
   input  logic [SELW-1:0] sel,
   mux_rr_nto1_reg_if.slave bus
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_ch_q,   out_ch_d;
   logic             out_valid_q, out_valid_d;
   logic [SELW-1:0]  last_q,     last_d;

   logic             load_en;
   logic             grant_valid;
   logic [SELW-1:0]  grant_idx;
   logic [N-1:0]     in_ready;
   logic             xfer_in;

   // Pick the granted channel and derive the per-channel ready strobes.
   // An out-of-range sel simply never matches a channel, so it grants nothing.
   always_comb begin
      int c;
      c           = 0;
      load_en     = !out_valid_q || bus.out_ready;
      grant_valid = 1'b0;
      grant_idx   = '0;
      if (!mode) begin
         for (int i = 0; i < N; i++) begin
            if (int'(sel) == i && bus.in_valid[i]) begin
               grant_valid = 1'b1;
               grant_idx   = SELW'(i);
            end
         end
      end else begin
         for (int k = 1; k <= N; k++) begin
            c = (int'(last_q) + k) % N;
            if (!grant_valid && bus.in_valid[c]) begin
               grant_valid = 1'b1;
               grant_idx   = SELW'(c);
            end
         end
      end
      // rst_n gating keeps every ready low while the block is held in reset.
      for (int i = 0; i < N; i++) begin
         in_ready[i] = rst_n && load_en && grant_valid && (grant_idx == SELW'(i));
      end
   end

   // Next value of the output register and the round-robin pointer.
   always_comb begin
      xfer_in     = load_en && grant_valid;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      last_d      = last_q;
      if (xfer_in) begin
         out_data_d  = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
         out_ch_d    = grant_idx;
         out_valid_d = 1'b1;
         last_d      = grant_idx;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output register; last resets to N-1 so channel 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         last_q      <= SELW'(N-1);
      end else begin
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         last_q      <= last_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_nto1_reg.sv
// Bench for mux_rr_nto1_reg: an N=4/WIDTH=8 instance driven through directed
// and random cycles against a small grant model and an output scoreboard,
// plus an N=3/WIDTH=16 instance exercising an out-of-range select.
module tb_mux_rr_nto1_reg;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mode;
   logic [1:0] sel;
   logic       mode3;
   logic [1:0] sel3;

   always #5 clk = ~clk;

   mux_rr_nto1_reg_if #(.WIDTH(8),  .N(4)) if4 ();
   mux_rr_nto1_reg_if #(.WIDTH(16), .N(3)) if3 ();

   mux_rr_nto1_reg #(.WIDTH(8), .N(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .mode  (mode),
      .sel   (sel),
      .bus   (if4)
   );

   mux_rr_nto1_reg #(.WIDTH(16), .N(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .mode  (mode3),
      .sel   (sel3),
      .bus   (if3)
   );

   typedef struct {
      int         ch;
      logic [7:0] d;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] din[4];
   int         m_last;
   bit         m_ov;
   int         n_checks = 0;
   int         n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference grant: -1 when nothing is granted.
   function automatic int model_grant(input bit md, input int s, input logic [3:0] v,
                                      input int last);
      if (!md) begin
         if (s < 4 && v[s]) return s;
         return -1;
      end
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (last + k) % 4;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   // One clock cycle; inputs are already set at the falling edge.
   task automatic step();
      int         g;
      logic [3:0] exp_rdy;
      exp_t       e;
      if4.in_data = {din[3], din[2], din[1], din[0]};
      #1;
      g       = model_grant(mode, int'(sel), if4.in_valid, m_last);
      exp_rdy = 4'b0000;
      if (g >= 0 && (!m_ov || if4.out_ready)) exp_rdy[g] = 1'b1;
      chk("in_ready", 32'(if4.in_ready), 32'(exp_rdy));
      if (m_ov && if4.out_ready) begin
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("out_valid", 32'(if4.out_valid), 32'd1);
            chk("out_ch",    32'(if4.out_ch),    32'(e.ch));
            chk("out_data",  32'(if4.out_data),  32'(e.d));
         end else begin
            chk("sb_depth", 32'(sbq.size()), 32'd1);
         end
      end
      if (exp_rdy != 4'b0000) begin
         e.ch = g;
         e.d  = din[g];
         sbq.push_back(e);
      end
      @(posedge clk);
      if (exp_rdy != 4'b0000) begin
         m_ov   = 1'b1;
         m_last = g;
      end else if (m_ov && if4.out_ready) begin
         m_ov = 1'b0;
      end
      #1;
      chk("out_valid_nxt", 32'(if4.out_valid), 32'(m_ov));
      @(negedge clk);
   endtask

   // Assert reset (checking the immediate effect), hold, release at a falling edge.
   task automatic do_reset();
      rst_n  = 1'b0;
      m_ov   = 1'b0;
      m_last = 3;
      sbq.delete();
      #1;
      chk("rst_out_valid", 32'(if4.out_valid), 32'd0);
      chk("rst_out_data",  32'(if4.out_data),  32'd0);
      chk("rst_out_ch",    32'(if4.out_ch),    32'd0);
      chk("rst_in_ready",  32'(if4.in_ready),  32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      mode          = 1'b0;
      sel           = 2'd0;
      if4.in_valid  = 4'b0000;
      if4.out_ready = 1'b1;
      if4.in_data   = '0;
      din           = '{8'h00, 8'h00, 8'h00, 8'h00};
      mode3         = 1'b0;
      sel3          = 2'd3;
      if3.in_valid  = 3'b111;
      if3.out_ready = 1'b1;
      if3.in_data   = {16'hBEEF, 16'h2222, 16'h1111};
      do_reset();

      // Round-robin rotation with all channels valid.
      din           = '{8'h10, 8'h11, 8'h12, 8'h13};
      mode          = 1'b1;
      if4.in_valid  = 4'b1111;
      if4.out_ready = 1'b1;
      repeat (5) step();
      if4.in_valid = 4'b0000;
      step();

      // Fixed select, then a select pointing at an idle channel.
      mode         = 1'b0;
      sel          = 2'd2;
      if4.in_valid = 4'b0101;
      step();
      sel = 2'd1;
      step();

      // Back-pressure: first word holds while the consumer stalls.
      do_reset();
      din           = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      mode          = 1'b1;
      if4.in_valid  = 4'b1010;
      if4.out_ready = 1'b0;
      repeat (3) step();
      if4.out_ready = 1'b1;
      step();
      if4.in_valid = 4'b0000;
      step();

      // Round-robin wrap-around and skip.
      mode         = 1'b0;
      sel          = 2'd1;
      if4.in_valid = 4'b0010;
      step();
      mode         = 1'b1;
      if4.in_valid = 4'b0001;
      step();
      if4.in_valid = 4'b1001;
      step();
      if4.in_valid = 4'b0000;
      step();

      // Reset while a channel-2 word is held.
      din           = '{8'h50, 8'h51, 8'h52, 8'h53};
      mode          = 1'b0;
      sel           = 2'd2;
      if4.in_valid  = 4'b0100;
      if4.out_ready = 1'b0;
      step();
      chk("pre_rst_ch", 32'(if4.out_ch), 32'd2);
      if4.in_valid  = 4'b1111;
      if4.out_ready = 1'b1;
      do_reset();
      mode = 1'b1;
      step();
      if4.in_valid = 4'b0000;
      step();

      // Random traffic.
      for (int i = 0; i < 60; i++) begin
         mode          = 1'($urandom_range(0, 1));
         sel           = 2'($urandom_range(0, 3));
         if4.in_valid  = 4'($urandom_range(0, 15));
         if4.out_ready = 1'($urandom_range(0, 3) != 0);
         for (int j = 0; j < 4; j++) din[j] = 8'($urandom_range(0, 255));
         step();
      end
      if4.in_valid  = 4'b0000;
      if4.out_ready = 1'b1;
      step();

      // N=3: select index 3 is out of range and must never grant.
      repeat (4) begin
         @(posedge clk);
         #1;
         chk("n3_in_ready", 32'(if3.in_ready), 32'd0);
         chk("n3_out_valid", 32'(if3.out_valid), 32'd0);
      end
      @(negedge clk);
      sel3 = 2'd2;
      #1;
      chk("n3_sel2_ready", 32'(if3.in_ready), 32'b100);
      @(posedge clk);
      #1;
      chk("n3_out_valid2", 32'(if3.out_valid), 32'd1);
      chk("n3_out_data",   32'(if3.out_data),  32'hBEEF);
      chk("n3_out_ch",     32'(if3.out_ch),    32'd2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mux_rr_nto1_reg.md
# mux_rr_nto1_reg

Parametrised N-to-1 registered data multiplexer with valid/ready handshaking on every input and on the output. Channel selection is either fixed, driven by an external select, or round-robin arbitration across requesting channels. It is the registered, multi-channel successor to the team's combinational 2-to-1 byte mux. It sits between several producers and one consumer wherever a shared datapath needs back-pressure and fair access.

## Interface
- WIDTH, 8, data width per channel
- N, 4, number of input channels (N ≥ 2)
- SELW, $clog2(N), width of the channel index
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- MODE  in  1  0 = fixed select via SEL; 1 = round-robin arbitration
- SEL  in  SELW  channel index used when MODE = 0
- IN_DATA  in  N*WIDTH  channel i at IN_DATA[i*WIDTH +: WIDTH]
- IN_VALID  in  N  per-channel valid
- IN_READY  out  N  per-channel ready; at most one bit high in any cycle
- OUT_DATA  out  WIDTH  registered output data
- OUT_VALID  out  1  output holds a valid word
- OUT_READY  in  1  consumer accepts OUT_DATA
- OUT_CH  out  SELW  index of the channel that produced OUT_DATA

## Operation
- Single output register stage.
- load_en = !OUT_VALID || OUT_READY.
- Grant, MODE = 0:
  - Channel g = SEL, valid only if SEL < N and IN_VALID[SEL] = 1.
  - SEL ≥ N means no grant.
- Grant, MODE = 1:
  - Search channels LAST+1, LAST+2, … modulo N.
  - The first channel with IN_VALID high is granted.
  - If no IN_VALID bit is high, there is no grant.
- IN_READY[g] = load_en && grant_valid. All other IN_READY bits are 0.
- IN_READY is combinational from IN_VALID, MODE, SEL, OUT_VALID, OUT_READY and LAST.
- Input transfer: IN_VALID[g] && IN_READY[g]. On a transfer:
  - OUT_DATA ← channel g data
  - OUT_CH ← g
  - OUT_VALID ← 1
  - LAST ← g (in both modes)
- Output transfer: OUT_VALID && OUT_READY.
  - If a new input transfer happens in the same cycle, the register reloads and OUT_VALID stays 1.
  - Otherwise OUT_VALID ← 0.
- OUT_VALID = 1 and OUT_READY = 0:
  - OUT_DATA and OUT_CH hold stable.
  - All IN_READY bits are 0.
- MODE or SEL changes take effect in the same cycle's grant. There is no internal state change on a mode switch; LAST is retained.
- A channel may drop IN_VALID without a transfer. No state changes in that case.

## Timing
- Reset (RST_N low, asynchronous): OUT_VALID = 0, OUT_DATA = 0, OUT_CH = 0, LAST = N-1, so channel 0 has first priority after reset.
- IN_READY = 0 while in reset.
- Release of RST_N is synchronised externally; the block needs no extra cycle after release.
- Latency: a word accepted at edge k appears on OUT_DATA/OUT_VALID after edge k, so it is visible in cycle k+1.
- Throughput: 1 word per cycle while OUT_READY = 1, including back-to-back transfers from different channels.
- Reset asserted mid-operation: the held output word is discarded, outputs go to reset values immediately, and LAST returns to N-1.
- Round-robin fairness: with all N channels continuously valid and OUT_READY = 1, grants rotate 0,1,…,N-1,0,… The maximum wait for a valid channel is N-1 transfers.
- LAST wraps from N-1 to 0 modulo N. For non-power-of-2 N, indices ≥ N are never granted.

## Test plan
- Reset, then MODE = 1, IN_VALID = 4'b1111, OUT_READY = 1, channel data 8'h10/11/12/13 -> OUT_CH sequence 0,1,2,3,0 on consecutive cycles. OUT_DATA 8'h10,11,12,13,10. OUT_VALID high from the first cycle after the first grant.
- MODE = 0, SEL = 2, IN_VALID = 4'b0101, OUT_READY = 1 -> IN_READY = 4'b0100, OUT_DATA = channel 2 data, OUT_CH = 2. Then SEL = 1 -> IN_READY = 0, OUT_VALID falls after the pending word is consumed.
- Back-pressure: MODE = 1, IN_VALID = 4'b1010, OUT_READY held 0 for 3 cycles -> first word (channel 1) loads and holds stable. IN_READY = 0 during the stall. After OUT_READY = 1, channel 3 follows on the next edge.
- Round-robin skip: LAST = 1, IN_VALID = 4'b0001 -> channel 0 granted (wrap-around). Next with IN_VALID = 4'b1001 -> channel 3 granted.
- Reset mid-stream: assert RST_N = 0 while OUT_VALID = 1, OUT_CH = 2 -> OUT_VALID, OUT_DATA and OUT_CH go to 0 immediately. After release with IN_VALID = 4'b1111, channel 0 is granted first.
- N = 3, WIDTH = 16, MODE = 0, SEL = 3 -> no IN_READY asserted and OUT_VALID stays 0.
